// File: rtl/fifo_sync.sv
// Single-clock synchronous FIFO with registered read data and registered full/empty flags.
// Optional sticky overflow/underflow error outputs are enabled by defining FIFO_SYNC_ERRFLAG_EN.
module fifo_sync #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [WIDTH-1:0]         input_data,
    input  logic                     write_en,
    input  logic                     read_en,
    output logic [WIDTH-1:0]         output_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
`ifdef FIFO_SYNC_ERRFLAG_EN
    ,
    output logic                     overflow,
    output logic                     underflow
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_acc;
    logic             rd_acc;
    logic [CW-1:0]    count_nxt;

    // A read frees the head slot in the same edge, so a full FIFO can still accept a write.
    always_comb begin
        rd_acc    = read_en & ~empty;
        wr_acc    = write_en & (~full | rd_acc);
        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage is intentionally left unreset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= input_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            output_data <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr      <= rd_ptr + AW'(1);
                output_data <= mem[rd_ptr];
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == CW'(0));
        end
    end

`ifdef FIFO_SYNC_ERRFLAG_EN
    // Sticky error flags; cleared only by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_en && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (read_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// Directed self-checking bench for fifo_sync (WIDTH=8, DEPTH=16).
// Error-flag checks are compiled in when FIFO_SYNC_ERRFLAG_EN is defined.
`timescale 1ns/1ps
module tb_fifo_sync;

    logic       clk;
    logic       resetn;
    logic [7:0] input_data;
    logic       write_en;
    logic       read_en;
    logic [7:0] output_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
`ifdef FIFO_SYNC_ERRFLAG_EN
    logic       overflow;
    logic       underflow;
`endif

    int checks = 0;
    int errors = 0;

    fifo_sync #(.WIDTH(8), .DEPTH(16)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .input_data  (input_data),
        .write_en    (write_en),
        .read_en     (read_en),
        .output_data (output_data),
        .full        (full),
        .empty       (empty),
        .count       (count)
`ifdef FIFO_SYNC_ERRFLAG_EN
        ,
        .overflow    (overflow),
        .underflow   (underflow)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic write_word(input logic [7:0] d);
        @(negedge clk);
        input_data = d;
        write_en   = 1'b1;
        @(negedge clk);
        write_en   = 1'b0;
        input_data = 8'h00;
    endtask

    task automatic read_word();
        @(negedge clk);
        read_en = 1'b1;
        @(negedge clk);
        read_en = 1'b0;
    endtask

    task automatic write_read(input logic [7:0] d);
        @(negedge clk);
        input_data = d;
        write_en   = 1'b1;
        read_en    = 1'b1;
        @(negedge clk);
        write_en   = 1'b0;
        read_en    = 1'b0;
        input_data = 8'h00;
    endtask

    task automatic test_reset();
        resetn     = 1'b0;
        write_en   = 1'b0;
        read_en    = 1'b0;
        input_data = 8'h00;
        #10;
        checks++;
        if (output_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", output_data); end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++;
        if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            write_word(8'(i));
            read_word_gap();
        end
        checks++;
        if (count !== 5'd16) begin errors++; $display("FAIL fill_count got %0d exp 16", count); end
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", full); end
        checks++;
        if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty got %b exp 0", empty); end
        write_word(8'd16);
        checks++;
        if (count !== 5'd16) begin errors++; $display("FAIL overflow_count got %0d exp 16", count); end
`ifdef FIFO_SYNC_ERRFLAG_EN
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_flag got %b exp 1", overflow); end
`endif
    endtask

    // Idle cycle between strobes so pulses are spaced apart.
    task automatic read_word_gap();
        @(negedge clk);
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            read_word();
            checks++;
            if (output_data !== 8'(i)) begin errors++; $display("FAIL drain_data[%0d] got %h exp %h", i, output_data, 8'(i)); end
        end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty); end
        checks++;
        if (count !== 5'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", count); end
        read_word();
        checks++;
        if (output_data !== 8'd15) begin errors++; $display("FAIL underflow_hold got %h exp 0f", output_data); end
`ifdef FIFO_SYNC_ERRFLAG_EN
        checks++;
        if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_flag got %b exp 1", underflow); end
`endif
    endtask

    task automatic test_simul_empty();
        write_read(8'hAB);
        checks++;
        if (count !== 5'd1) begin errors++; $display("FAIL se_count got %0d exp 1", count); end
        checks++;
        if (output_data !== 8'd15) begin errors++; $display("FAIL se_hold got %h exp 0f", output_data); end
        read_word();
        checks++;
        if (output_data !== 8'hAB) begin errors++; $display("FAIL se_read got %h exp ab", output_data); end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL se_empty got %b exp 1", empty); end
    endtask

    task automatic test_simul_full();
        for (int i = 0; i < 16; i++) write_word(8'(i));
        write_read(8'h55);
        checks++;
        if (output_data !== 8'h00) begin errors++; $display("FAIL sf_data got %h exp 00", output_data); end
        checks++;
        if (count !== 5'd16) begin errors++; $display("FAIL sf_count got %0d exp 16", count); end
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL sf_full got %b exp 1", full); end
        for (int i = 1; i < 17; i++) begin
            logic [7:0] exp;
            exp = (i == 16) ? 8'h55 : 8'(i);
            read_word();
            checks++;
            if (output_data !== exp) begin errors++; $display("FAIL sf_drain[%0d] got %h exp %h", i, output_data, exp); end
        end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL sf_empty got %b exp 1", empty); end
    endtask

    task automatic test_wrap();
        logic [7:0] q[$];
        logic [7:0] exp;
        for (int i = 0; i < 3; i++) begin
            write_word(8'(8'h80 + i));
            q.push_back(8'(8'h80 + i));
        end
        for (int i = 0; i < 40; i++) begin
            q.push_back(8'(8'h90 + i));
            exp = q.pop_front();
            write_read(8'(8'h90 + i));
            checks++;
            if (output_data !== exp) begin errors++; $display("FAIL wrap_data[%0d] got %h exp %h", i, output_data, exp); end
        end
        checks++;
        if (count !== 5'd3) begin errors++; $display("FAIL wrap_count got %0d exp 3", count); end
    endtask

    task automatic test_midop_reset();
        write_word(8'h11);
        write_word(8'h22);
        checks++;
        if (count !== 5'd5) begin errors++; $display("FAIL mid_pre_count got %0d exp 5", count); end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (count !== 5'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", count); end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty got %b exp 1", empty); end
        checks++;
        if (output_data !== 8'h00) begin errors++; $display("FAIL mid_data got %h exp 00", output_data); end
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL mid_full got %b exp 0", full); end
`ifdef FIFO_SYNC_ERRFLAG_EN
        checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL mid_flags got %b%b exp 00", overflow, underflow); end
`endif
        @(negedge clk);
        resetn = 1'b1;
        write_word(8'h3C);
        checks++;
        if (count !== 5'd1) begin errors++; $display("FAIL post_count got %0d exp 1", count); end
        read_word();
        checks++;
        if (output_data !== 8'h3C) begin errors++; $display("FAIL post_data got %h exp 3c", output_data); end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL post_empty got %b exp 1", empty); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_simul_empty();
        test_simul_full();
        test_wrap();
        test_midop_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_sync.md
Name: fifo_sync

Overview:
- Single-clock synchronous FIFO buffering fixed-width data words between a producer and a consumer in the same clock domain.
- Writes and reads are one-cycle strobes. Read data is registered.
- Writes while full and reads while empty are ignored safely, with no corruption of stored data or pointers.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of storage entries; must be a power of two, at least 2.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- input_data  input  WIDTH  write data, sampled on a rising edge when write_en=1.
- write_en  input  1  write strobe; one word per cycle while high.
- read_en  input  1  read strobe; one word per cycle while high.
- output_data  output  WIDTH  registered read data.
- full  output  1  high when count==DEPTH.
- empty  output  1  high when count==0.
- count  output  $clog2(DEPTH)+1  number of stored words.

Behaviour:
- Reset: on resetn low, immediately and asynchronously:
  - wr_ptr=0, rd_ptr=0, count=0.
  - output_data=0, empty=1, full=0.
  - Storage array contents are not reset.
- Write accept: wr_acc = write_en & (~full | rd_acc), evaluated on the rising edge.
  - On wr_acc: mem[wr_ptr] <= input_data; wr_ptr increments modulo DEPTH.
- Read accept: rd_acc = read_en & ~empty.
  - On rd_acc: output_data <= mem[rd_ptr]; rd_ptr increments modulo DEPTH.
  - Latency: the word is valid on output_data after the same edge (1-cycle registered latency).
- output_data holds its last value when no read is accepted, including a rejected read on empty.
- count update: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
- full and empty are derived from the registered count, so they are glitch-free registered-equivalent flags.
- Full + write without read: write dropped; stored data, pointers and count unchanged.
- Full + write + read: both accepted. Head word goes to output_data, new word enters the freed slot, count stays DEPTH.
- Empty + read without write: read ignored; output_data and pointers unchanged.
- Empty + write + read: no bypass path.
  - Write accepted, read rejected.
  - output_data unchanged; count becomes 1.
- Wrap-around: pointers roll from DEPTH-1 to 0 transparently. FIFO order is preserved across wrap.
- Reset asserted mid-operation: all contents are logically discarded (count=0, empty=1) at once. The first operation after reset release behaves as on a fresh FIFO.
- X handling: input_data is don't-care when wr_acc=0.

Optional Feature:
- Macro: FIFO_SYNC_ERRFLAG_EN.
- Defined: adds two outputs, overflow (1 bit) and underflow (1 bit). Both reset to 0.
  - overflow is set on any edge where write_en=1 and the write is dropped.
  - underflow is set on any edge where read_en=1 while empty.
  - Both are sticky until resetn is asserted.
- Not defined: these ports and their logic do not exist. Data-path behaviour is identical in both builds.

Test Plan:
- Reset then idle: resetn low 10 ns -> output_data=0, empty=1, full=0, count=0.
- Fill: write 0..15 with one-cycle write_en pulses spaced apart -> count=16, full=1, empty=0. A 17th write of 16 is dropped: count stays 16; overflow=1 if FIFO_SYNC_ERRFLAG_EN.
- Drain: 16 one-cycle read_en pulses -> output_data=0,1,...,15 in order, each valid after its read edge; empty=1 at end. A 17th read leaves output_data=15; underflow=1 if enabled.
- Simultaneous on empty: input_data=0xAB, write_en=read_en=1 for one cycle -> count=1, output_data stays 15. A later read yields 0xAB.
- Simultaneous on full: fill with 0..15, then write 0x55 plus read in the same cycle -> output_data=0, count=16. A subsequent drain yields 1..15 then 0x55.
- Wrap and mid-op reset: write/read interleaved 40 words, checking order across pointer wrap. Then with 5 words stored assert resetn -> count=0, empty=1, output_data=0 asynchronously, before the next clock edge.
